// File: rtl/conv_idx_pkg.sv
// Shared types and helpers for the convolution window index generator.
package conv_idx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Valid (unpadded) output extent along one axis; degenerate geometry yields 0.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned stride);
    if (stride == 0 || k > img) return 0;
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_window_index_gen_wrap_counter.sv
// Modulo counter with carry-out; several are chained wrap->inc to form a loop nest.
module wrap_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         inc,
  input  logic [W-1:0] max,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = inc && (cnt == max);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/conv_window_index_gen.sv
// Loop-nest index generator: walks output pixels and kernel taps, streaming
// the flat input-feature-map address of each tap over valid/ready.
module conv_window_index_gen
  import conv_idx_pkg::*;
#(
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned K_H      = 3,
  parameter int unsigned K_W      = 3,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  oy,
  output logic [IDX_W-1:0]  ox,
  output logic [IDX_W-1:0]  ch,
  output logic [IDX_W-1:0]  ky,
  output logic [IDX_W-1:0]  kx,
  output logic [ADDR_W-1:0] in_addr,
  output logic              win_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUT_H = out_dim(IMG_H, K_H, STRIDE);
  localparam int unsigned OUT_W = out_dim(IMG_W, K_W, STRIDE);
  localparam int unsigned MAX_HW = (OUT_H > OUT_W) ? OUT_H : OUT_W;
  localparam int unsigned MAX_CK = (K_H > K_W) ? K_H : K_W;
  localparam int unsigned MAX_A  = (MAX_HW > MAX_CK) ? MAX_HW : MAX_CK;
  localparam int unsigned MAX_DIM = (MAX_A > CHANNELS) ? MAX_A : CHANNELS;

  if (K_H > IMG_H || K_W > IMG_W || STRIDE < 1) begin : g_bad_geometry
    $fatal(1, "conv_window_index_gen: kernel larger than image or STRIDE < 1");
  end
  if ((longint'(1) << ADDR_W) < longint'(CHANNELS) * longint'(IMG_H) * longint'(IMG_W))
  begin : g_bad_addr_w
    $fatal(1, "conv_window_index_gen: ADDR_W too narrow for the feature map");
  end
  if ((longint'(1) << IDX_W) <= longint'(MAX_DIM)) begin : g_bad_idx_w
    $fatal(1, "conv_window_index_gen: IDX_W too narrow for the loop bounds");
  end

  localparam logic [IDX_W-1:0] KW_MAX = IDX_W'(K_W - 1);
  localparam logic [IDX_W-1:0] KH_MAX = IDX_W'(K_H - 1);
  localparam logic [IDX_W-1:0] CH_MAX = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] OW_MAX = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] OH_MAX = IDX_W'(OUT_H - 1);

  state_t state, state_nx;
  logic   accept;
  logic   wrap_kx, wrap_ky, wrap_ch, wrap_ox, wrap_oy;

  assign accept = out_valid && out_ready;

  // Fastest-first chain: kx -> ky -> ch -> ox -> oy; the oy carry ends the frame.
  wrap_counter #(.W(IDX_W)) u_kx (.clock(clock), .nreset(nreset), .inc(accept),
    .max(KW_MAX), .clear(clear), .cnt(kx), .wrap(wrap_kx));
  wrap_counter #(.W(IDX_W)) u_ky (.clock(clock), .nreset(nreset), .inc(wrap_kx),
    .max(KH_MAX), .clear(clear), .cnt(ky), .wrap(wrap_ky));
  wrap_counter #(.W(IDX_W)) u_ch (.clock(clock), .nreset(nreset), .inc(wrap_ky),
    .max(CH_MAX), .clear(clear), .cnt(ch), .wrap(wrap_ch));
  wrap_counter #(.W(IDX_W)) u_ox (.clock(clock), .nreset(nreset), .inc(wrap_ch),
    .max(OW_MAX), .clear(clear), .cnt(ox), .wrap(wrap_ox));
  wrap_counter #(.W(IDX_W)) u_oy (.clock(clock), .nreset(nreset), .inc(wrap_ox),
    .max(OH_MAX), .clear(clear), .cnt(oy), .wrap(wrap_oy));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = RUN;
      RUN:     if (wrap_oy) state_nx = DONE;
      DONE:                 state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] c, input logic i,
                                            input logic w);
    return i ? (w ? '0 : c + 1'b1) : c;
  endfunction

  // Mirror of the counters' next values so address and flags land with the indices.
  logic [IDX_W-1:0]  nkx, nky, nch, nox, noy;
  logic [ADDR_W-1:0] row_nx, addr_nx;
  logic              go_run, win_nx, frame_nx;

  always_comb begin
    nkx      = step(kx, accept,  wrap_kx);
    nky      = step(ky, wrap_kx, wrap_ky);
    nch      = step(ch, wrap_ky, wrap_ch);
    nox      = step(ox, wrap_ch, wrap_ox);
    noy      = step(oy, wrap_ox, wrap_oy);
    go_run   = (state_nx == RUN);
    row_nx   = ADDR_W'(nch) * ADDR_W'(IMG_H) + ADDR_W'(noy) * ADDR_W'(STRIDE) + ADDR_W'(nky);
    addr_nx  = '0;
    if (go_run)
      addr_nx = row_nx * ADDR_W'(IMG_W) + ADDR_W'(nox) * ADDR_W'(STRIDE) + ADDR_W'(nkx);
    win_nx   = go_run && (nkx == KW_MAX) && (nky == KH_MAX) && (nch == CH_MAX);
    frame_nx = win_nx && (nox == OW_MAX) && (noy == OH_MAX);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_addr    <= '0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      out_valid  <= go_run;
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == DONE);
      in_addr    <= addr_nx;
      win_last   <= win_nx;
      frame_last <= frame_nx;
    end
  end

endmodule
